// File: rtl/apb_multi_slave_bridge_if.sv
// rtl/apb_multi_slave_bridge_if.sv - request/response and shared APB bus bundle for the multi-slave bridge
interface apb_multi_slave_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int PROT_WIDTH = 3,
  parameter int NUM_SLAVES = 4
);
  logic                             MREQ;
  logic [ADDR_WIDTH-1:0]            MADDR;
  logic                             MWRITE;
  logic [DATA_WIDTH-1:0]            MWDATA;
  logic [DATA_WIDTH/8-1:0]          MSTRB;
  logic [PROT_WIDTH-1:0]            MPROT;
  logic                             MREADY;
  logic [DATA_WIDTH-1:0]            MRDATA;
  logic                             MSLVERR;
  logic [ADDR_WIDTH-1:0]            PADDR;
  logic                             PWRITE;
  logic [DATA_WIDTH-1:0]            PWDATA;
  logic [DATA_WIDTH/8-1:0]          PSTRB;
  logic [PROT_WIDTH-1:0]            PPROT;
  logic [NUM_SLAVES-1:0]            PSEL;
  logic                             PENABLE;
  logic [NUM_SLAVES-1:0]            PREADY_S;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA_S;
  logic [NUM_SLAVES-1:0]            PSLVERR_S;

  // master: the bridge itself; slave: requester plus the APB slaves around it
  modport master (
    input  MREQ, MADDR, MWRITE, MWDATA, MSTRB, MPROT, PREADY_S, PRDATA_S, PSLVERR_S,
    output MREADY, MRDATA, MSLVERR, PADDR, PWRITE, PWDATA, PSTRB, PPROT, PSEL, PENABLE
  );
  modport slave (
    output MREQ, MADDR, MWRITE, MWDATA, MSTRB, MPROT, PREADY_S, PRDATA_S, PSLVERR_S,
    input  MREADY, MRDATA, MSLVERR, PADDR, PWRITE, PWDATA, PSTRB, PPROT, PSEL, PENABLE
  );
endinterface

// File: rtl/apb_multi_slave_bridge.sv
// rtl/apb_multi_slave_bridge.sv - APB requester bridge with N-slave decode and response mux
// Optional ACCESS wait timeout enabled by defining APB_TIMEOUT_EN.
module apb_multi_slave_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int PROT_WIDTH     = 3,
  parameter int NUM_SLAVES     = 4,
  parameter int SEL_LSB        = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  apb_multi_slave_bridge_if.master bus
);
  localparam int SEL_BITS = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [SEL_BITS:0] SLAVE_COUNT = (SEL_BITS+1)'(NUM_SLAVES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DERR} state_t;

  state_t                state, state_d;
  logic [SEL_BITS-1:0]   idx, idx_q;
  logic                  hit, accept, complete, abort, timed_out;
  logic [NUM_SLAVES-1:0] sel_dec;
  logic                  sel_ready, sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;

  assign idx = bus.MADDR[SEL_LSB +: SEL_BITS];
  assign hit = {1'b0, idx} < SLAVE_COUNT;

  // Decode of the incoming index and response mux keyed on the latched index
  always_comb begin
    sel_dec   = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel_dec[i] = (idx == SEL_BITS'(i));
      if (idx_q == SEL_BITS'(i)) begin
        sel_ready = bus.PREADY_S[i];
        sel_err   = bus.PSLVERR_S[i];
        sel_rdata = bus.PRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_BITS-1:0] wait_cnt;

  always_ff @(posedge PCLK) begin
    if (PRESET || state != ACCESS) begin
      wait_cnt <= '0;
    end else if (!sel_ready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // True on the edge that would complete the TIMEOUT_CYCLES-th unanswered wait
  assign timed_out = (wait_cnt == CNT_BITS'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d  = state;
    accept   = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.MREQ && !bus.MREADY) begin
          accept  = 1'b1;
          state_d = hit ? SETUP : DERR;
        end
      end
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (sel_ready) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (timed_out) begin
          abort   = 1'b1;
          state_d = DERR;
        end
      end
      DERR:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // DERR doubles as the error-completion cycle for both decode misses and timeouts
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      bus.PADDR   <= '0;
      bus.PWRITE  <= 1'b0;
      bus.PWDATA  <= '0;
      bus.PSTRB   <= '0;
      bus.PPROT   <= '0;
      bus.PSEL    <= '0;
      bus.PENABLE <= 1'b0;
      bus.MREADY  <= 1'b0;
      bus.MSLVERR <= 1'b0;
      bus.MRDATA  <= '0;
      idx_q       <= '0;
    end else begin
      bus.MREADY  <= 1'b0;
      bus.MSLVERR <= 1'b0;
      bus.MRDATA  <= '0;
      if (accept) begin
        bus.PADDR  <= bus.MADDR;
        bus.PWRITE <= bus.MWRITE;
        bus.PWDATA <= bus.MWDATA;
        bus.PSTRB  <= bus.MSTRB;
        bus.PPROT  <= bus.MPROT;
        bus.PSEL   <= sel_dec;
        idx_q      <= idx;
      end
      if (state == SETUP) bus.PENABLE <= 1'b1;
      if (complete || abort) begin
        bus.PSEL    <= '0;
        bus.PENABLE <= 1'b0;
      end
      if (complete) begin
        bus.MREADY  <= 1'b1;
        bus.MSLVERR <= sel_err;
        bus.MRDATA  <= bus.PWRITE ? '0 : sel_rdata;
      end
      if (state == DERR) begin
        bus.MREADY  <= 1'b1;
        bus.MSLVERR <= 1'b1;
      end
    end
  end
endmodule
